// File: rtl/text_console_writer.sv
// rtl/text_console_writer.sv - byte stream to text-mode VRAM writer with cursor and control codes
//
// Turns characters and control codes into VRAM writes for a COLS x ROWS text grid.
// Character codes go to the char plane (0..COLS*ROWS-1) and attribute bytes go to
// the colour plane (COLOR_OFS..). Supports CR, LF, BS and FF (clear screen).
//
// Ports:
//   clk, rst_n               clock, async active-low reset
//   in_data/in_valid/in_ready byte input handshake (accepted only in IDLE)
//   color                    attribute byte, sampled with in_data on accept
//   vram_wr_en/addr/data     VRAM write port, addr/data zero when not writing
//   busy                     FSM not in IDLE
//   cursor_x, cursor_y       current cursor position

module text_console_writer #(
  parameter int           COLS      = 180,
  parameter int           ROWS      = 56,
  parameter int           COLOR_OFS = 10080,
  parameter logic [7:0]   CLR_CHAR  = 8'h20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  color,
  output logic        vram_wr_en,
  output logic [14:0] vram_wr_addr,
  output logic [7:0]  vram_wr_data,
  output logic        busy,
  output logic [7:0]  cursor_x,
  output logic [5:0]  cursor_y
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_CHAR,
    S_WR_COLOR,
    S_CLR_CHAR,
    S_CLR_COLOR
  } state_t;

  localparam logic [14:0] OFS      = 15'(COLOR_OFS);
  localparam logic [14:0] COLS15   = 15'(COLS);
  localparam logic [7:0]  X_MAX    = 8'(COLS - 1);
  localparam logic [5:0]  Y_MAX    = 6'(ROWS - 1);
  localparam logic [13:0] CLR_LAST = 14'(COLS * ROWS - 1);

  state_t      state;
  logic [14:0] cell_addr;   // tracks cursor_y*COLS + cursor_x incrementally
  logic [13:0] clr_idx;
  logic [7:0]  color_q;

  assign in_ready = (state == S_IDLE);
  assign busy     = (state != S_IDLE);

  // Write outputs are registered so that the value present while in a write
  // state is the write belonging to that state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      cell_addr    <= '0;
      clr_idx      <= '0;
      color_q      <= '0;
      cursor_x     <= '0;
      cursor_y     <= '0;
      vram_wr_en   <= 1'b0;
      vram_wr_addr <= '0;
      vram_wr_data <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            case (in_data)
              8'h0D: begin
                cursor_x  <= '0;
                cell_addr <= cell_addr - {7'd0, cursor_x};
              end
              8'h0A: begin
                cursor_x <= '0;
                if (cursor_y == Y_MAX) begin
                  cursor_y  <= '0;
                  cell_addr <= '0;
                end else begin
                  cursor_y  <= cursor_y + 6'd1;
                  cell_addr <= cell_addr - {7'd0, cursor_x} + COLS15;
                end
              end
              8'h08: begin
                if (cursor_x != 8'd0) begin
                  cursor_x  <= cursor_x - 8'd1;
                  cell_addr <= cell_addr - 15'd1;
                end
              end
              8'h0C: begin
                color_q      <= color;
                clr_idx      <= '0;
                state        <= S_CLR_CHAR;
                vram_wr_en   <= 1'b1;
                vram_wr_addr <= '0;
                vram_wr_data <= CLR_CHAR;
              end
              default: begin
                color_q      <= color;
                state        <= S_WR_CHAR;
                vram_wr_en   <= 1'b1;
                vram_wr_addr <= cell_addr;
                vram_wr_data <= in_data;
              end
            endcase
          end
        end

        S_WR_CHAR: begin
          state        <= S_WR_COLOR;
          vram_wr_addr <= cell_addr + OFS;
          vram_wr_data <= color_q;
        end

        S_WR_COLOR: begin
          state        <= S_IDLE;
          vram_wr_en   <= 1'b0;
          vram_wr_addr <= '0;
          vram_wr_data <= '0;
          if (cursor_x == X_MAX) begin
            cursor_x <= '0;
            // Last cell of the screen wraps to the top; no scrolling.
            if (cursor_y == Y_MAX) begin
              cursor_y  <= '0;
              cell_addr <= '0;
            end else begin
              cursor_y  <= cursor_y + 6'd1;
              cell_addr <= cell_addr + 15'd1;
            end
          end else begin
            cursor_x  <= cursor_x + 8'd1;
            cell_addr <= cell_addr + 15'd1;
          end
        end

        S_CLR_CHAR: begin
          state        <= S_CLR_COLOR;
          vram_wr_addr <= {1'b0, clr_idx} + OFS;
          vram_wr_data <= color_q;
        end

        S_CLR_COLOR: begin
          if (clr_idx == CLR_LAST) begin
            state        <= S_IDLE;
            vram_wr_en   <= 1'b0;
            vram_wr_addr <= '0;
            vram_wr_data <= '0;
            cursor_x     <= '0;
            cursor_y     <= '0;
            cell_addr    <= '0;
          end else begin
            state        <= S_CLR_CHAR;
            clr_idx      <= clr_idx + 14'd1;
            vram_wr_addr <= {1'b0, clr_idx + 14'd1};
            vram_wr_data <= CLR_CHAR;
          end
        end

        default: begin
          state        <= S_IDLE;
          vram_wr_en   <= 1'b0;
          vram_wr_addr <= '0;
          vram_wr_data <= '0;
        end
      endcase
    end
  end

endmodule
